// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers.
// The inverse S-box is computed arithmetically (inverse affine, then field inverse).
package aes_pkg;

  localparam int AES_NR  = 10;
  localparam int AES_BLK = 128;
  localparam int AES_KW  = (AES_NR + 1) * AES_BLK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_decrypt_seq_round_key_sel.sv
// Round-counter-indexed selection of one 128-bit slot from the round-key bus.
module round_key_sel
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = AES_KW
) (
  input  logic [$clog2(NR+1)-1:0] rnd,
  input  logic [KW-1:0]           round_keys,
  output logic [AES_BLK-1:0]      key
);
  localparam int RW = $clog2(NR + 1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    key = '0;
    for (int k = 0; k <= NR; k++) begin
      if (rnd == RW'(k)) key = round_keys[k*AES_BLK +: AES_BLK];
    end
  end
endmodule

// File: rtl/aes_inv_prims.sv
// Inverse-cipher building blocks. Byte i of a block is bits [127-8i -: 8] and
// bytes are column-major (byte r+4c is row r, column c), as in FIPS-197.
module inv_shift_rows
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data,
  output logic [AES_BLK-1:0] result
);
  always_comb begin
    result = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        result[127-8*(r+4*c) -: 8] = data[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
  end
endmodule

module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data,
  output logic [AES_BLK-1:0] result
);
  always_comb begin
    result = '0;
    for (int i = 0; i < 16; i++) begin
      result[i*8 +: 8] = inv_sbox(data[i*8 +: 8]);
    end
  end
endmodule

module addRoundKey
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data,
  input  logic [AES_BLK-1:0] round_key,
  output logic [AES_BLK-1:0] result
);
  assign result = data ^ round_key;
endmodule

module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data,
  output logic [AES_BLK-1:0] result
);
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  always_comb begin
    result = '0;
    for (int c = 0; c < 4; c++) begin
      result[127-32*c -: 32] = mix_col(data[127-32*c -: 32]);
    end
  end
endmodule

// One middle round of the straightforward inverse cipher:
// InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module decryptRound
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data,
  input  logic [AES_BLK-1:0] round_key,
  output logic [AES_BLK-1:0] result
);
  logic [AES_BLK-1:0] sr, sb, ak;

  inv_shift_rows  u_sr (.data(data), .result(sr));
  inv_sub_bytes   u_sb (.data(sr),   .result(sb));
  addRoundKey     u_ak (.data(sb),   .round_key(round_key), .result(ak));
  inv_mix_columns u_mc (.data(ak),   .result(result));
endmodule

// File: rtl/aes_decrypt_seq.sv
// Iterative AES-128 decryptor: one shared middle round reused for rounds 1..9,
// a separate final round, ready/valid handshakes on both sides, held output.
module aes_decrypt_seq
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = AES_KW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AES_BLK-1:0] in_data,
  input  logic [KW-1:0]      round_keys,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AES_BLK-1:0] out_data,
  output logic               busy
);
  localparam int RW = $clog2(NR + 1);
  localparam logic [RW-1:0] LAST_RND = RW'(NR - 1);

  state_t             state_q, state_d;
  logic [RW-1:0]      rnd_q, rnd_d;
  logic [AES_BLK-1:0] st_q, st_d;
  logic [AES_BLK-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [AES_BLK-1:0] round_key, round_out;
  logic [AES_BLK-1:0] fin_sr, fin_sb, fin_out;
  logic               accept;

  // Ready depends on out_ready only, so a DONE-cycle accept never loops through in_valid.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  round_key_sel #(.NR(NR), .KW(KW)) u_key_sel (
    .rnd        (rnd_q),
    .round_keys (round_keys),
    .key        (round_key)
  );

  decryptRound u_round (.data(st_q), .round_key(round_key), .result(round_out));

  inv_shift_rows u_fin_sr (.data(st_q),   .result(fin_sr));
  inv_sub_bytes  u_fin_sb (.data(fin_sr), .result(fin_sb));
  addRoundKey    u_fin_ak (
    .data      (fin_sb),
    .round_key (round_keys[NR*AES_BLK +: AES_BLK]),
    .result    (fin_out)
  );

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    st_d        = st_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: ;
      ST_ROUND: begin
        st_d  = round_out;
        rnd_d = rnd_q + RW'(1);
        if (rnd_q == LAST_RND) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        out_data_d  = fin_out;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept is only possible in IDLE or in a consumed DONE, so it overrides those arms.
    if (accept) begin
      st_d    = in_data ^ round_keys[0 +: AES_BLK];
      rnd_d   = RW'(1);
      state_d = ST_ROUND;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rnd_q       <= '0;
      st_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// Scoreboard bench for aes_decrypt_seq: the driver pushes expected plaintexts on
// accept, a negedge monitor pops and compares on every output handshake.
module tb_aes_decrypt_seq;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [1407:0]  round_keys;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           busy;

  aes_decrypt_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .round_keys (round_keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [127:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: forward AES-128 ----------------
  logic [7:0]   sb[256];
  logic [127:0] rk[11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic build_keys(input logic [127:0] key);
    logic [31:0] w[44];
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    // The decryptor consumes keys in reverse: slot 0 is the last encryption key.
    for (int k = 0; k <= 10; k++) round_keys[k*128 +: 128] = rk[10-k];
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s, t;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb[s[127-8*i -: 8]];
      t = s;
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          s[127-8*(row+4*c) -: 8] = t[127-8*(row+4*((c+row)%4)) -: 8];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          {a0, a1, a2, a3} = s[127-32*c -: 32];
          s[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = s ^ rk[r];
    end
    return s;
  endfunction

  // ---------------- monitor ----------------
  logic         prev_valid = 1'b0;
  logic         prev_hs    = 1'b0;
  logic [127:0] prev_data  = '0;
  int           last_acc_edge = 0;
  bit           b2b_mode = 0;
  bit           b2b_have_prev = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        check("hold_valid", 128'(out_valid), 128'd1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && !prev_valid)
        check("latency", 128'(cyc - last_acc_edge), 128'd10);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", out_data, 128'hx);
        else check("result", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (b2b_mode && b2b_have_prev)
          check("b2b_interval", 128'(cyc + 1 - last_acc_edge), 128'd11);
        b2b_have_prev = b2b_mode;
        last_acc_edge = cyc + 1;
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    bit done = 0;
    in_data  = ct;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(pt);
        done = 1;
      end
      @(posedge clk); #1;
    end
    check("accept_in_time", 128'(done), 128'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("valid_in_time", 128'(seen), 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_time", 128'(exp_q.size()), 128'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [127:0] pts[8];
  logic [127:0] cts[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; round_keys = '0;
    build_sbox();
    build_keys(128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 8; i++) begin
      pts[i] = {32'h0123_4567 + 32'(i), 32'h89ab_cdef ^ {4{8'(i * 17)}}, 32'hdead_beef, 32'(i) * 32'h1111_1111};
      cts[i] = aes_enc(pts[i]);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_data", out_data, 128'd0);

    // FIPS-197 C.1
    out_ready = 1'b1;
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
    check("busy_in_round", 128'(busy), 128'd1);
    drain();

    // Back-pressure, with ignored in_valid pulses
    out_ready = 1'b0;
    send(cts[0], pts[0]);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 0);
      in_data  = cts[5];
      @(negedge clk);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Simultaneous consume + accept in DONE
    out_ready = 1'b0;
    send(cts[1], pts[1]);
    wait_valid();
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    send(cts[2], pts[2]);
    drain();

    // Back-to-back, 8 blocks
    out_ready = 1'b1;
    b2b_mode  = 1;
    for (int i = 0; i < 8; i++) send(cts[i], pts[i]);
    b2b_mode  = 0;
    drain();

    // Ignore while busy
    send(cts[3], pts[3]);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = cts[6];
      @(negedge clk);
      check("busy_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset at rnd == 5
    send(cts[4], pts[4]);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("mid_rst_no_output", 128'(out_valid), 128'd0);
    end
    @(posedge clk); #1;
    send(cts[7], pts[7]);
    drain();

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
